// File: rtl/axis_fifo_rd_ctrl.sv
// Reads one packet of pkt_len words from a latency-1 FIFO and replays it on an
// AXI-Stream master through a 2-entry skid buffer, with TLAST on the final word.
module axis_fifo_rd_ctrl #(
    parameter int C_M_AXIS_TDATA_WIDTH = 32,
    parameter int LEN_WIDTH            = 16
) (
    input  logic                              rd_clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [LEN_WIDTH-1:0]              pkt_len,
    output logic                              busy,
    output logic                              done,
    output logic                              fifo_rd_en,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   fifo_dout,
    input  logic                              fifo_empty,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TKEEP,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                          r_state;
    state_t                          w_state_next;
    logic [LEN_WIDTH-1:0]            r_len;
    logic [LEN_WIDTH-1:0]            r_rd_cnt;
    logic [LEN_WIDTH-1:0]            r_tx_cnt;
    logic [1:0]                      r_occ;
    logic                            r_inflight;
    logic                            r_done;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] r_buf [2];

    logic                            w_accept;
    logic                            w_hs;
    logic                            w_last_word;
    logic [1:0]                      w_occ_pop;
    logic [2:0]                      w_commit;
    logic [LEN_WIDTH-1:0]            w_len_m1;

    assign w_accept    = (r_state == S_IDLE) && start && (pkt_len != '0);
    assign w_hs        = M_AXIS_TVALID && M_AXIS_TREADY;
    assign w_occ_pop   = r_occ - {1'b0, w_hs};
    // Entries already owned by the buffer once this cycle's pop is taken out.
    assign w_commit    = {1'b0, w_occ_pop} + {2'b00, r_inflight};
    assign w_len_m1    = r_len - LEN_WIDTH'(1);
    assign w_last_word = w_hs && M_AXIS_TLAST;

    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign M_AXIS_TVALID = (r_occ != 2'd0);
    assign M_AXIS_TDATA  = r_buf[0];
    assign M_AXIS_TKEEP  = '1;
    assign M_AXIS_TLAST  = M_AXIS_TVALID && (r_tx_cnt == w_len_m1);

    assign fifo_rd_en = (r_state == S_RUN) && !fifo_empty &&
                        (r_rd_cnt < r_len) && (w_commit < 3'd2);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN:   if (fifo_rd_en && (r_rd_cnt == w_len_m1)) w_state_next = S_DRAIN;
            S_DRAIN: if (w_last_word) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_len      <= '0;
            r_rd_cnt   <= '0;
            r_tx_cnt   <= '0;
            r_occ      <= 2'd0;
            r_inflight <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= fifo_rd_en;
            r_occ      <= w_occ_pop + {1'b0, r_inflight};
            r_done     <= w_last_word;
            if (w_accept) begin
                r_len    <= pkt_len;
                r_rd_cnt <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (fifo_rd_en) r_rd_cnt <= r_rd_cnt + LEN_WIDTH'(1);
                if (w_hs)       r_tx_cnt <= r_tx_cnt + LEN_WIDTH'(1);
            end
        end
    end

    // Head shifts on a pop; the returning word lands behind whatever survives it.
    always_ff @(posedge rd_clk) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
        end else begin
            if (w_hs)       r_buf[0]            <= r_buf[1];
            if (r_inflight) r_buf[w_occ_pop[0]] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_axis_fifo_rd_ctrl.sv
// Self-checking bench: table of packets plus hand-written underflow, busy-start
// and mid-packet reset sequences, with a beat scoreboard fed by the stimulus.
module tb_axis_fifo_rd_ctrl;

    localparam int DW = 32;
    localparam int LW = 8;

    logic            rd_clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [LW-1:0]   pkt_len = '0;
    logic            busy;
    logic            done;
    logic            fifo_rd_en;
    logic [DW-1:0]   fifo_dout = '0;
    logic            fifo_empty = 1'b1;
    logic            M_AXIS_TVALID;
    logic [DW-1:0]   M_AXIS_TDATA;
    logic [DW/8-1:0] M_AXIS_TKEEP;
    logic            M_AXIS_TLAST;
    logic            M_AXIS_TREADY = 1'b1;

    axis_fifo_rd_ctrl #(
        .C_M_AXIS_TDATA_WIDTH(DW),
        .LEN_WIDTH(LW)
    ) dut (
        .rd_clk(rd_clk),
        .rst(rst),
        .start(start),
        .pkt_len(pkt_len),
        .busy(busy),
        .done(done),
        .fifo_rd_en(fifo_rd_en),
        .fifo_dout(fifo_dout),
        .fifo_empty(fifo_empty),
        .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TKEEP(M_AXIS_TKEEP),
        .M_AXIS_TLAST(M_AXIS_TLAST),
        .M_AXIS_TREADY(M_AXIS_TREADY)
    );

    always #5 rd_clk = ~rd_clk;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    typedef struct {
        int            len;
        logic [DW-1:0] base;
        int            rmode;
        int            exp_beats;
        int            exp_done;
        int            exp_first;
        int            exp_done_cyc;
    } vec_t;

    int            total = 0;
    int            bad = 0;
    int            beat_cnt = 0;
    int            done_cnt = 0;
    logic [DW-1:0] fq [$];
    exp_t          exp_q [$];
    exp_t          mon_e;
    logic [DW-1:0] fifo_tmp;
    logic          prev_stall = 1'b0;
    logic          prev_last_hs = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_tlast = 1'b0;
    vec_t          vecs [6];

    // Behavioural FIFO, standard mode, read latency 1.
    always @(posedge rd_clk) begin
        if (fifo_rd_en) begin
            total++;
            if (fifo_empty || fq.size() == 0) begin
                bad++;
                $display("FAIL rd_en_while_empty: rd_en=1 empty=%0b, required rd_en=0", fifo_empty);
            end else begin
                fifo_tmp = fq.pop_front();
                fifo_dout <= fifo_tmp;
            end
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Stream monitor and scoreboard.
    always @(negedge rd_clk) begin
        if (rst) begin
            prev_stall   <= 1'b0;
            prev_last_hs <= 1'b0;
        end else begin
            total++;
            if (done !== prev_last_hs) begin
                bad++;
                $display("FAIL done_timing: done=%0b required=%0b", done, prev_last_hs);
            end
            if (done) begin
                done_cnt++;
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_at_done: busy=%0b required=0", busy);
                end
            end
            if (prev_stall) begin
                total++;
                if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== prev_data || M_AXIS_TLAST !== prev_tlast) begin
                    bad++;
                    $display("FAIL stall_hold: valid=%0b data=0x%0h last=%0b required valid=1 data=0x%0h last=%0b",
                             M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST, prev_data, prev_tlast);
                end
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                beat_cnt++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_beat: data=0x%0h, required no beat", M_AXIS_TDATA);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (M_AXIS_TDATA !== mon_e.data || M_AXIS_TLAST !== mon_e.last || M_AXIS_TKEEP !== '1) begin
                        bad++;
                        $display("FAIL beat: data=0x%0h last=%0b keep=0x%0h required data=0x%0h last=%0b keep=0xf",
                                 M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TKEEP, mon_e.data, mon_e.last);
                    end
                end
            end
            prev_stall   <= M_AXIS_TVALID && !M_AXIS_TREADY;
            prev_data    <= M_AXIS_TDATA;
            prev_tlast   <= M_AXIS_TLAST;
            prev_last_hs <= M_AXIS_TVALID && M_AXIS_TREADY && M_AXIS_TLAST;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic push_fifo(input logic [DW-1:0] d);
        fq.push_back(d);
    endtask

    task automatic push_exp(input logic [DW-1:0] d, input logic l);
        exp_t e;
        e.data = d;
        e.last = l;
        exp_q.push_back(e);
    endtask

    task automatic wait_done(input string name, input int bound);
        int cyc;
        for (cyc = 0; cyc < bound; cyc++) begin
            @(negedge rd_clk);
            if (done) break;
            tick();
        end
        if (cyc >= bound) chk({name, "_timeout"}, 32'(cyc), 32'(bound - 1));
        tick();
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int first;
        int done_cyc;
        int bound;
        int cyc;
        beat_cnt = 0;
        done_cnt = 0;
        first    = -1;
        done_cyc = -1;
        for (int i = 0; i < v.len; i++) begin
            push_fifo(v.base + DW'(i));
            push_exp(v.base + DW'(i), i == v.len - 1);
        end
        repeat (2) tick();
        bound   = (v.len == 0) ? 20 : v.len * 4 + 20;
        start   = 1'b1;
        pkt_len = LW'(v.len);
        for (cyc = 0; cyc < bound; cyc++) begin
            @(negedge rd_clk);
            if (M_AXIS_TVALID && first < 0) first = cyc;
            if (v.len == 0) chk("len0_busy", 32'(busy), 32'd0);
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            start = 1'b0;
            M_AXIS_TREADY = (v.rmode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        tick();
        start = 1'b0;
        M_AXIS_TREADY = 1'b1;
        repeat (2) tick();
        chk("vec_beats", 32'(beat_cnt), 32'(v.exp_beats));
        chk("vec_done_count", 32'(done_cnt), 32'(v.exp_done));
        chk("vec_first_valid_cycle", 32'(first), 32'(v.exp_first));
        chk("vec_leftover_expected", 32'(exp_q.size()), 32'd0);
        if (v.exp_done_cyc >= 0) chk("vec_done_cycle", 32'(done_cyc), 32'(v.exp_done_cyc));
        $display("vec %0d: len=%0d rmode=%0d beats=%0d dones=%0d first=%0d done_cyc=%0d",
                 idx, v.len, v.rmode, beat_cnt, done_cnt, first, done_cyc);
    endtask

    initial begin
        logic [DW-1:0] h0;
        logic [DW-1:0] h1;
        int cyc;

        // len, base, tready mode, beats, dones, first TVALID cycle, done cycle
        vecs[0] = '{8,   32'h0000_0001, 0, 8,   1, 3,  11};
        vecs[1] = '{1,   32'h0000_0010, 0, 1,   1, 3,  4};
        vecs[2] = '{16,  32'h0000_0020, 1, 16,  1, 3,  -1};
        vecs[3] = '{0,   32'h0000_0000, 0, 0,   0, -1, -1};
        vecs[4] = '{255, 32'h0000_1000, 0, 255, 1, 3,  258};
        vecs[5] = '{5,   32'h0000_0050, 1, 5,   1, 3,  -1};

        rst = 1'b1;
        repeat (3) tick();
        @(negedge rd_clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rst_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rst_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("rst_tdata", M_AXIS_TDATA, 32'd0);
        chk("rst_tkeep", 32'(M_AXIS_TKEEP), 32'hf);
        $display("reset: busy=%0b tvalid=%0b tdata=0x%0h", busy, M_AXIS_TVALID, M_AXIS_TDATA);
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

        // Underflow: two words, a long empty gap, then the remaining two.
        beat_cnt = 0;
        done_cnt = 0;
        push_fifo(32'h200);
        push_fifo(32'h201);
        for (int i = 0; i < 4; i++) push_exp(32'h200 + DW'(i), i == 3);
        repeat (2) tick();
        start = 1'b1;
        pkt_len = LW'(4);
        tick();
        start = 1'b0;
        repeat (16) tick();
        @(negedge rd_clk);
        chk("uf_beats_mid", 32'(beat_cnt), 32'd2);
        chk("uf_busy_mid", 32'(busy), 32'd1);
        chk("uf_tvalid_mid", 32'(M_AXIS_TVALID), 32'd0);
        chk("uf_rd_en_mid", 32'(fifo_rd_en), 32'd0);
        chk("uf_done_mid", 32'(done_cnt), 32'd0);
        tick();
        push_fifo(32'h202);
        push_fifo(32'h203);
        wait_done("uf", 40);
        repeat (2) tick();
        chk("uf_beats", 32'(beat_cnt), 32'd4);
        chk("uf_done_count", 32'(done_cnt), 32'd1);
        chk("uf_leftover", 32'(exp_q.size()), 32'd0);
        $display("underflow: beats=%0d dones=%0d", beat_cnt, done_cnt);

        // Start while busy must not queue a second packet.
        beat_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            push_fifo(32'h300 + DW'(i));
            push_exp(32'h300 + DW'(i), i == 5);
        end
        repeat (2) tick();
        start = 1'b1;
        pkt_len = LW'(6);
        tick();
        start = 1'b0;
        repeat (2) tick();
        start = 1'b1;
        pkt_len = LW'(3);
        tick();
        start = 1'b0;
        wait_done("busy_start", 40);
        repeat (10) tick();
        @(negedge rd_clk);
        chk("bs_busy_after", 32'(busy), 32'd0);
        chk("bs_tvalid_after", 32'(M_AXIS_TVALID), 32'd0);
        chk("bs_beats", 32'(beat_cnt), 32'd6);
        chk("bs_done_count", 32'(done_cnt), 32'd1);
        chk("bs_fifo_untouched", 32'(fq.size()), 32'd0);
        $display("start_while_busy: beats=%0d dones=%0d", beat_cnt, done_cnt);
        tick();

        // Reset after three beats of an 8-word packet, with a read in flight.
        beat_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) push_fifo(32'h400 + DW'(i));
        for (int i = 0; i < 8; i++) push_exp(32'h400 + DW'(i), i == 7);
        repeat (2) tick();
        start = 1'b1;
        pkt_len = LW'(8);
        tick();
        start = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            @(negedge rd_clk);
            if (beat_cnt >= 3) break;
            tick();
        end
        if (cyc >= 40) chk("rs_reach3_timeout", 32'(cyc), 32'd39);
        tick();
        rst = 1'b1;
        start = 1'b1;
        pkt_len = LW'(5);
        tick();
        rst = 1'b0;
        start = 1'b0;
        @(negedge rd_clk);
        chk("rs_busy", 32'(busy), 32'd0);
        chk("rs_done", 32'(done), 32'd0);
        chk("rs_rd_en", 32'(fifo_rd_en), 32'd0);
        chk("rs_tvalid", 32'(M_AXIS_TVALID), 32'd0);
        chk("rs_tlast", 32'(M_AXIS_TLAST), 32'd0);
        chk("rs_tdata", M_AXIS_TDATA, 32'd0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            tick();
            @(negedge rd_clk);
            chk("rs_idle_tvalid", 32'(M_AXIS_TVALID), 32'd0);
            chk("rs_idle_busy", 32'(busy), 32'd0);
        end
        tick();
        h0 = fq[0];
        h1 = fq[1];
        push_exp(h0, 1'b0);
        push_exp(h1, 1'b1);
        beat_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        pkt_len = LW'(2);
        tick();
        start = 1'b0;
        wait_done("rs_pkt2", 30);
        repeat (2) tick();
        chk("rs_pkt2_beats", 32'(beat_cnt), 32'd2);
        chk("rs_pkt2_done_count", 32'(done_cnt), 32'd1);
        chk("rs_pkt2_leftover", 32'(exp_q.size()), 32'd0);
        $display("reset_mid_packet: post-reset beats=%0d head=0x%0h,0x%0h", beat_cnt, h0, h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axis_fifo_rd_ctrl.md
AXIS_FIFO_RD_CTRL -- requirements
Module: axis_fifo_rd_ctrl

Interface
REQ-001 The block SHALL have a single clock and a synchronous, active-high reset.
REQ-002 Parameter C_M_AXIS_TDATA_WIDTH, default 32: stream and FIFO data width in bits; multiple of 8.
REQ-003 Parameter LEN_WIDTH, default 16: width of the packet-length field and of both internal counters.
REQ-004 Ports SHALL be exactly:
- rd_clk  in  1  clock; also drives the read port of the FIFO.
- rst  in  1  synchronous reset, active high.
- start  in  1  single-cycle request to send one packet.
- pkt_len  in  LEN_WIDTH  packet length in words; sampled when start is accepted.
- busy  out  1  packet in progress.
- done  out  1  one-cycle pulse after the last word is transferred.
- fifo_rd_en  out  1  FIFO read enable; the FIFO uses standard mode with read latency 1.
- fifo_dout  in  C_M_AXIS_TDATA_WIDTH  FIFO read data.
- fifo_empty  in  1  FIFO empty flag.
- M_AXIS_TVALID  out  1  stream data valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
- M_AXIS_TKEEP  out  C_M_AXIS_TDATA_WIDTH/8  byte qualifier.
- M_AXIS_TLAST  out  1  last word of the packet.
- M_AXIS_TREADY  in  1  downstream ready.

Function
REQ-005 The state machine SHALL have three states: IDLE, RUN and DRAIN.
REQ-006 In IDLE, start=1 with pkt_len!=0 SHALL latch pkt_len, clear rd_cnt and tx_cnt, and enter RUN on the next edge.
REQ-007 start with pkt_len=0 SHALL be ignored: the state stays IDLE and done is not pulsed.
REQ-008 start asserted in RUN or DRAIN SHALL be ignored, with no queuing.
REQ-009 busy SHALL be 1 exactly when the state is RUN or DRAIN.
REQ-010 The output buffer SHALL be a 2-entry FIFO-ordered buffer with occupancy occ in 0..2; inflight SHALL be 1 in the cycle after fifo_rd_en=1.
REQ-011 fifo_rd_en SHALL be 1 only when all of the following hold:
- the state is RUN;
- fifo_empty=0;
- rd_cnt < latched length;
- occ + inflight - (M_AXIS_TVALID & M_AXIS_TREADY) < 2.
REQ-012 Each fifo_rd_en=1 SHALL increment rd_cnt.
REQ-013 When rd_cnt reaches the latched length, the state SHALL move from RUN to DRAIN.
REQ-014 fifo_dout SHALL be written into the buffer at the end of the cycle after fifo_rd_en=1; M_AXIS_TVALID SHALL rise in the following cycle.
- Minimum latency from the start cycle to the first TVALID is 3 cycles.
REQ-015 The buffer SHALL never overflow, and no word SHALL be dropped or duplicated.
REQ-016 Sustained throughput SHALL be 1 word per cycle while the FIFO is non-empty and TREADY=1.
REQ-017 M_AXIS_TVALID SHALL equal (occ!=0).
- M_AXIS_TDATA is the oldest buffered word.
- TDATA, TLAST and TKEEP SHALL be held stable while TVALID=1 and TREADY=0.
REQ-018 M_AXIS_TKEEP SHALL be all ones.
REQ-019 M_AXIS_TLAST SHALL be 1 exactly when TVALID=1 and tx_cnt equals latched length-1.
REQ-020 Each handshake (TVALID & TREADY) SHALL pop one buffer entry and increment tx_cnt.
REQ-021 A buffer write and a handshake in the same cycle SHALL leave occ unchanged and preserve word order.
REQ-022 The handshake on the TLAST word SHALL:
- pulse done=1 in the next cycle;
- return the state to IDLE on the same edge.
- If the length is 1, this SHALL hold with the state passing through RUN and DRAIN.
REQ-023 When fifo_empty=1 in RUN, the block SHALL stall with no timeout; TVALID drops once the buffer empties.
REQ-024 The block SHALL ignore fifo_empty in IDLE and DRAIN.
REQ-025 Length arithmetic SHALL be unsigned LEN_WIDTH; the maximum length 2^LEN_WIDTH-1 SHALL complete without counter wrap.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL, from any state including mid-packet:
- set the state to IDLE;
- clear rd_cnt, tx_cnt, occ and inflight;
- set busy, done, fifo_rd_en, M_AXIS_TVALID and M_AXIS_TLAST to 0, and M_AXIS_TDATA to 0.
REQ-027 A FIFO word returned after a read issued in the cycle before reset SHALL be discarded.
REQ-028 start SHALL be ignored in any cycle where rst=1.

Verification
REQ-029 Basic packet: FIFO preloaded with 0x1..0x8, TREADY=1, start with pkt_len=8.
- Required: 8 consecutive TVALID beats carrying 0x1..0x8.
- TLAST is 1 on 0x8 only.
- done pulses once, 1 cycle after that beat; busy falls on the same edge.
REQ-030 Backpressure: pkt_len=16 with TREADY toggled at random.
- Required: all 16 words in order, none lost or duplicated.
- occ never exceeds 2, and TDATA is stable during stalls.
REQ-031 Underflow: pkt_len=4 with 2 words available, then the FIFO stays empty for 10 cycles before 2 more words arrive.
- Required: fifo_rd_en stays 0 while empty, and the state stays RUN.
- The packet completes with TLAST on the 4th word.
REQ-032 Edge lengths:
- pkt_len=1: single beat with TLAST=1, then done.
- pkt_len=0: no activity, busy stays 0.
- start while busy: no effect on the current packet.
REQ-033 Reset mid-packet: rst=1 after 3 of 8 words have been transferred.
- Required: outputs return to 0 on the next edge and the state is IDLE.
- The next start with pkt_len=2 produces exactly 2 beats from the FIFO head.
